// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the byte-serial fp adder front end
package fp_pkg;

  localparam int FP_W        = 32;
  localparam int BYTE_W      = 8;
  localparam int CMD_SUB_BIT = 0;
  localparam logic [BYTE_W-1:0] CMD_RSVD_MASK = 8'hFE;

  typedef enum logic [2:0] {
    S_CMD  = 3'd0,
    S_A    = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_SEND = 3'd4
  } fp_serdes_state_t;

  function automatic logic cmd_is_valid(input logic [BYTE_W-1:0] cmd);
    return (cmd & CMD_RSVD_MASK) == '0;
  endfunction

endpackage

// File: rtl/fp_byte_shreg.sv
// rtl/fp_byte_shreg.sv - 32-bit byte shift register: load byte at LSB, shift out MSB, or parallel load
module fp_byte_shreg
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_byte,
  input  logic              shift_out,
  input  logic              load_word,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic [FP_W-1:0]   word_in,
  output logic [FP_W-1:0]   word_out
);

  logic [FP_W-1:0] data_q;
  logic [FP_W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_word) begin
      data_d = word_in;
    end else if (load_byte) begin
      data_d = {data_q[FP_W-BYTE_W-1:0], byte_in};
    end else if (shift_out) begin
      data_d = {data_q[FP_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign word_out = data_q;

endmodule

// File: rtl/fp_byte_serdes.sv
// rtl/fp_byte_serdes.sv - byte-serial command/operand loader and result streamer around fp_addsub
module fp_byte_serdes
  import fp_pkg::*;
#(
  parameter int EXEC_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [BYTE_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FP_W-1:0]     op_a,
  output logic [FP_W-1:0]     op_b,
  output logic                op_sub,
  input  logic [FP_W-1:0]     fp_result,
  output logic                busy,
  output logic                cmd_err
);

  localparam logic [3:0] EXEC_INIT = 4'(EXEC_CYCLES - 1);

  fp_serdes_state_t state_q, state_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [3:0]       exec_cnt_q, exec_cnt_d;
  logic             op_sub_q, op_sub_d;
  logic             cmd_err_q, cmd_err_d;

  logic             in_fire;
  logic             out_fire;
  logic             a_load;
  logic             b_load;
  logic             res_capture;
  logic             res_shift;
  logic [FP_W-1:0]  res_word;

  // Handshake outputs are pure state decodes so neither side sees a combinational loop.
  assign in_ready  = (state_q == S_CMD) || (state_q == S_A) || (state_q == S_B);
  assign out_valid = (state_q == S_SEND);
  assign busy      = (state_q != S_CMD);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    exec_cnt_d  = exec_cnt_q;
    op_sub_d    = op_sub_q;
    cmd_err_d   = 1'b0;
    a_load      = 1'b0;
    b_load      = 1'b0;
    res_capture = 1'b0;
    res_shift   = 1'b0;
    case (state_q)
      S_CMD: begin
        if (in_fire) begin
          if (cmd_is_valid(in_data)) begin
            op_sub_d   = in_data[CMD_SUB_BIT];
            byte_cnt_d = 2'd0;
            state_d    = S_A;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_A: begin
        if (in_fire) begin
          a_load     = 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_B;
          end
        end
      end
      S_B: begin
        if (in_fire) begin
          b_load     = 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            exec_cnt_d = EXEC_INIT;
            state_d    = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        exec_cnt_d = exec_cnt_q - 4'd1;
        if (exec_cnt_q == 4'd0) begin
          res_capture = 1'b1;
          byte_cnt_d  = 2'd0;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (out_fire) begin
          res_shift  = 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = S_CMD;
          end
        end
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_CMD;
      byte_cnt_q <= 2'd0;
      exec_cnt_q <= 4'd0;
      op_sub_q   <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      exec_cnt_q <= exec_cnt_d;
      op_sub_q   <= op_sub_d;
      cmd_err_q  <= cmd_err_d;
    end
  end

  fp_byte_shreg u_a_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_byte (a_load),
    .shift_out (1'b0),
    .load_word (1'b0),
    .byte_in   (in_data),
    .word_in   ('0),
    .word_out  (op_a)
  );

  fp_byte_shreg u_b_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_byte (b_load),
    .shift_out (1'b0),
    .load_word (1'b0),
    .byte_in   (in_data),
    .word_in   ('0),
    .word_out  (op_b)
  );

  fp_byte_shreg u_res_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_byte (1'b0),
    .shift_out (res_shift),
    .load_word (res_capture),
    .byte_in   ('0),
    .word_in   (fp_result),
    .word_out  (res_word)
  );

  assign out_data = res_word[FP_W-1:FP_W-BYTE_W];
  assign op_sub   = op_sub_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_fp_byte_serdes.sv
// tb/tb_fp_byte_serdes.sv - self-checking bench for fp_byte_serdes with a transaction-level model
module tb_fp_byte_serdes;

  localparam int EXEC = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_sub;
  logic [31:0] fp_result;
  logic        busy;
  logic        cmd_err;

  int checks   = 0;
  int failures = 0;
  bit rnd_rdy  = 0;

  byte unsigned got_q[$];

  fp_byte_serdes #(.EXEC_CYCLES(EXEC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_sub    (op_sub),
    .fp_result (fp_result),
    .busy      (busy),
    .cmd_err   (cmd_err)
  );

  // Stand-in for fp_addsub: exact for the directed vectors, an arbitrary mixing function elsewhere.
  function automatic logic [31:0] adder_stub(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 && s)  return 32'h4000_0000;
    return (a + {b[15:0], b[31:16]}) ^ (s ? 32'hA5A5_5A5A : 32'h0000_0000);
  endfunction

  assign fp_result = adder_stub(op_a, op_b, op_sub);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction model
  bit          m_cmd_seen;
  int          m_n;
  logic [31:0] m_a, m_b;
  bit          m_sub;
  int          m_wait;
  bit          m_err;
  byte unsigned m_out[$];

  always @(negedge clk) begin
    logic [31:0] r;
    bit exp_ready, exp_ov, exp_busy;
    if (!rst_n) begin
      m_cmd_seen = 0; m_n = 0; m_a = '0; m_b = '0; m_sub = 0; m_wait = 0; m_err = 0;
      m_out.delete();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
      chk("rst_op_a", op_a, 32'd0);
      chk("rst_op_b", op_b, 32'd0);
      chk("rst_op_sub", {31'd0, op_sub}, 32'd0);
    end else begin
      exp_ov    = m_out.size() > 0;
      exp_ready = !(m_wait > 0 || exp_ov);
      exp_busy  = m_cmd_seen || !exp_ready;
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("cmd_err", {31'd0, cmd_err}, {31'd0, m_err});
      chk("op_a", op_a, m_a);
      chk("op_b", op_b, m_b);
      chk("op_sub", {31'd0, op_sub}, {31'd0, m_sub});
      if (exp_ov) chk("out_data", {24'd0, out_data}, {24'd0, m_out[0]});

      m_err = 0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          r = adder_stub(m_a, m_b, m_sub);
          m_out.push_back(r[31:24]); m_out.push_back(r[23:16]);
          m_out.push_back(r[15:8]);  m_out.push_back(r[7:0]);
        end
      end
      if (exp_ov && out_ready) begin
        got_q.push_back(out_data);
        void'(m_out.pop_front());
      end
      if (exp_ready && in_valid) begin
        if (!m_cmd_seen) begin
          if (in_data[7:1] == 7'd0) begin
            m_cmd_seen = 1; m_sub = in_data[0]; m_n = 0;
          end else begin
            m_err = 1;
          end
        end else begin
          if (m_n < 4) m_a = {m_a[23:0], in_data};
          else         m_b = {m_b[23:0], in_data};
          m_n++;
          if (m_n == 8) begin
            m_cmd_seen = 0;
            m_wait = EXEC;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      n++;
      if (n > 200) begin
        chk("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b, input int gap);
    send_byte(cmd, gap);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8], gap);
    for (int i = 3; i >= 0; i--) send_byte(b[i*8 +: 8], gap);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        chk("idle_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] got_word();
    if (got_q.size() != 4) return 32'hDEAD_BEEF;
    return {got_q[0], got_q[1], got_q[2], got_q[3]};
  endfunction

  initial begin
    int lat;
    logic [7:0] cmd;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Add with latency measurement
    out_ready = 1'b1;
    send_txn(8'h00, 32'h3F80_0000, 32'h4000_0000, 0);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid || lat > 20) break;
      lat++;
    end
    chk("add_latency", lat, 2);
    wait_idle();
    chk("add_result", got_word(), 32'h4040_0000);
    got_q.delete();

    // Subtract
    send_txn(8'h01, 32'h4040_0000, 32'h3F80_0000, 0);
    wait_idle();
    chk("sub_result", got_word(), 32'h4000_0000);
    got_q.delete();

    // Backpressure then single-cycle ready pulses
    out_ready = 1'b0;
    send_txn(8'h00, 32'h3F80_0000, 32'h4000_0000, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_data", {24'd0, out_data}, 32'h40);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      @(posedge clk); #1;
      chk("bp_pulse_count", got_q.size(), k + 1);
    end
    chk("bp_result", got_word(), 32'h4040_0000);
    got_q.delete();
    out_ready = 1'b1;

    // Bad command, single and back-to-back
    send_byte(8'h02, 0);
    @(negedge clk);
    chk("bad_cmd_err", {31'd0, cmd_err}, 32'd1);
    chk("bad_cmd_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("bad_cmd_err_clear", {31'd0, cmd_err}, 32'd0);
    @(posedge clk); #1;
    send_byte(8'hFF, 0);
    send_byte(8'h80, 0);
    send_txn(8'h01, 32'h4040_0000, 32'h3F80_0000, 0);
    wait_idle();
    chk("after_bad_result", got_word(), 32'h4000_0000);
    got_q.delete();

    // Reset mid-load
    send_byte(8'h00, 0);
    send_byte(8'h3F, 0);
    send_byte(8'h80, 0);
    rst_n = 1'b0;
    #2;
    chk("midrst_op_a", op_a, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("midrst_no_output", got_q.size(), 0);
    send_txn(8'h00, 32'h3F80_0000, 32'h4000_0000, 0);
    wait_idle();
    chk("midrst_result", got_word(), 32'h4040_0000);
    got_q.delete();

    // Gapped input, then in_valid held high through EXEC
    send_txn(8'h00, 32'h3F80_0000, 32'h4000_0000, 2);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(negedge clk);
    chk("exec_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_idle();
    chk("gap_result", got_word(), 32'h4040_0000);
    got_q.delete();

    // Randomized transactions checked by the model
    rnd_rdy = 1;
    for (int t = 0; t < 40; t++) begin
      cmd = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'($urandom_range(0, 1));
      if (cmd[7:1] != 7'd0) begin
        send_byte(cmd, $urandom_range(0, 2));
      end else begin
        send_txn(cmd, $urandom, $urandom, $urandom_range(0, 1));
        wait_idle();
      end
    end
    rnd_rdy = 0;
    out_ready = 1'b1;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_byte_serdes.md
# fp_byte_serdes

Byte-serial front/back end for the floating-point adder. Accepts a command byte and two IEEE-754 single-precision operands over an 8-bit valid/ready input stream. It drives the operands and the add/sub select to the combinational `fp_addsub` stage, waits a programmable settle time, then captures the 32-bit result. The result is streamed back out MSB-byte first on an 8-bit valid/ready output stream.

## Interface
- `EXEC_CYCLES`, default 2: cycles the adder inputs are held stable before the result is captured; legal range 1..15.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  8  input byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `out_data`  out  8  output result byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  sink consumes `out_data` this cycle.
- `op_a`  out  32  operand A to `fp_addsub.a`; registered.
- `op_b`  out  32  operand B to `fp_addsub.b`; registered.
- `op_sub`  out  1  to `fp_addsub.sub`; registered.
- `fp_result`  in  32  `fp_addsub.result`.
- `busy`  out  1  high in every state except `S_CMD`.
- `cmd_err`  out  1  one-cycle pulse when a command byte is rejected.

## Operation

Transfers:
- An input byte is transferred on a rising edge with `in_valid & in_ready`.
- An output byte is transferred on a rising edge with `out_valid & out_ready`.

States:
- `S_CMD`: `in_ready=1`.
  - Byte with bits[7:1]==0: `op_sub<=byte[0]`, go to `S_A`, `byte_cnt<=0`.
  - Any other byte: dropped; `cmd_err` pulses the next cycle; state stays `S_CMD`; `op_sub` is unchanged.
- `S_A`: `in_ready=1`.
  - Each byte shifts into `op_a` from the LSB end: `op_a<={op_a[23:0],byte}`, so the first byte ends up in [31:24].
  - After the 4th byte, `byte_cnt<=0` and go to `S_B`.
- `S_B`: same as `S_A`, filling `op_b`.
  - After the 4th byte, go to `S_EXEC` with `exec_cnt<=EXEC_CYCLES-1`.
- `S_EXEC`: `in_ready=0`.
  - Decrement `exec_cnt` each cycle.
  - On the cycle `exec_cnt==0`: `res_reg<=fp_result`, `byte_cnt<=0`, go to `S_SEND`.
- `S_SEND`: `out_valid=1`, `out_data=res_reg[31:24]`.
  - Each output transfer: `res_reg<={res_reg[23:0],8'h00}`.
  - After the 4th transfer, go to `S_CMD`.

Operand registers:
- `op_a`, `op_b` and `op_sub` are written only in the states above.
- They hold their values through `S_EXEC`, `S_SEND` and the following `S_CMD`, so the adder output stays stable for the whole transaction.

Other rules:
- `out_valid` is 0 outside `S_SEND`.
- The input does not stall the output; no overlap between transactions is allowed.
- The block does no floating-point interpretation; NaN, Inf and subnormal bit patterns pass through untouched.
- `byte_cnt` is 2 bits; `exec_cnt` is 4 bits.

## Timing

Reset values (`rst_n` low, asynchronous):
- state `S_CMD`
- `op_a`=0, `op_b`=0, `op_sub`=0, `res_reg`=0
- counters 0
- `cmd_err`=0, `out_valid`=0, `busy`=0
- `in_ready`=1: it is a decode of state, so it is high in reset.

Latency and throughput:
- The edge accepting the last B byte enters `S_EXEC`.
- The result is captured on the `EXEC_CYCLES`-th edge after it.
- `out_valid` rises that same edge. Latency from the last-B-byte edge to the first `out_valid` cycle is `EXEC_CYCLES` cycles.
- Best-case transaction: 9 input cycles, then `EXEC_CYCLES` cycles, then 4 output cycles.

Handshake rules:
- `in_ready` and `out_valid` depend only on state (no combinational path from `in_valid`/`out_ready`).
- `out_data` is stable while `out_valid & ~out_ready`.

Boundary conditions:
- `cmd_err` is registered, asserted exactly 1 cycle per rejected byte. Back-to-back bad bytes give a pulse in consecutive cycles.
- Reset mid-transaction aborts immediately. Partial operands are cleared. No output is produced for the aborted transaction.
- `in_valid` asserted during `S_EXEC`/`S_SEND` is ignored; the byte is not consumed.

## Structure
- Shared package `fp_pkg`:
  - state enum `fp_serdes_state_t` (`S_CMD`, `S_A`, `S_B`, `S_EXEC`, `S_SEND`)
  - `FP_W=32`, `BYTE_W=8`
  - `CMD_SUB_BIT=0`, `CMD_RSVD_MASK=8'hFE`
- One natural sub-module: `fp_byte_shreg`, a 32-bit shift register with load-byte-at-LSB and shift-out-MSB modes. It is used three times (A, B, result).
- `fp_addsub` is instantiated by the parent, not inside this block.

## Test plan
- Bench connects `op_a`, `op_b`, `op_sub` and `fp_result` to an `fp_addsub` instance; `EXEC_CYCLES`=2.
- Add: send 00, 3F 80 00 00, 40 00 00 00 -> output bytes 40 40 00 00 (1.0+2.0=3.0). `out_valid` rises exactly 2 cycles after the last input edge.
- Subtract: send 01, 40 40 00 00, 3F 80 00 00 -> 40 00 00 00 (3.0-1.0).
- Backpressure: hold `out_ready`=0 for 5 cycles during `S_SEND` -> `out_data` stays 40 with `out_valid`=1. Each 1-cycle `out_ready` pulse advances exactly one byte.
- Bad command: send 02 -> one-cycle `cmd_err` pulse, state stays `S_CMD`, `busy`=0. A following valid transaction completes correctly.
- Reset mid-load: assert `rst_n` low after 2 A bytes -> all outputs take their reset values. A full add transaction afterwards returns 40 40 00 00.
- Idle input: `in_valid` gaps between every input byte -> same result as back-to-back. `in_valid`=1 during `S_EXEC` is not consumed.
